// File: rtl/tlp_tx_arbiter_if.sv
// TX arbiter bus: per-requester TLP beat inputs, the shared TX channel
// toward the PCIe IP, and the grant/packet-count status outputs.
interface tlp_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0][63:0] reqData_in;
  logic [NUM_REQ-1:0]       reqValid_in;
  logic [NUM_REQ-1:0]       reqReady_out;
  logic [NUM_REQ-1:0]       reqSOP_in;
  logic [NUM_REQ-1:0]       reqEOP_in;
  logic [63:0]              txData_out;
  logic                     txValid_out;
  logic                     txReady_in;
  logic                     txSOP_out;
  logic                     txEOP_out;
  logic [NUM_REQ-1:0]       grant_out;
  logic [31:0]              pktCount_out;

  // arbiter side
  modport slave (
    input  reqData_in, reqValid_in, reqSOP_in, reqEOP_in, txReady_in,
    output reqReady_out, txData_out, txValid_out, txSOP_out, txEOP_out,
           grant_out, pktCount_out
  );

  // requesters + PCIe IP side
  modport master (
    output reqData_in, reqValid_in, reqSOP_in, reqEOP_in, txReady_in,
    input  reqReady_out, txData_out, txValid_out, txSOP_out, txEOP_out,
           grant_out, pktCount_out
  );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Packet-level round-robin arbiter merging NUM_REQ TLP streams onto one
// 64-bit PCIe TX channel. A TLP owns the channel from SOP acceptance until
// EOP acceptance; arbitration is combinational so an idle channel forwards
// a new SOP beat with zero latency.

// Per-requester slice: eligibility for a new packet and ready steering.
module tlp_tx_arb_lane (
  input  logic i_sel,
  input  logic i_valid,
  input  logic i_sop,
  input  logic i_txReady,
  output logic o_elig,
  output logic o_grant,
  output logic o_ready
);
  assign o_elig  = i_valid & i_sop;
  assign o_grant = i_sel;
  assign o_ready = i_sel & i_txReady;
endmodule

module tlp_tx_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic pcieClk_in,
  input  logic reset_in,
  tlp_tx_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  typedef logic [IW-1:0] idx_t;
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state;
  idx_t        r_rrPtr;
  idx_t        r_lockIdx;
  idx_t        r_holdIdx;   // idle-state pick waiting on txReady
  logic        r_hold;
  logic [31:0] r_pktCount;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  idx_t               w_pick;
  idx_t               w_cand;
  idx_t               w_g;
  idx_t               w_rrNext;
  logic               w_found;
  logic               w_holdOk;
  logic               w_active;
  logic               w_txValid;
  logic               w_acc;

  // Search rrPtr, rrPtr+1, ... for the first requester presenting SOP;
  // walking k downward lets the lowest offset win.
  always_comb begin
    w_pick  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = idx_t'((int'(r_rrPtr) + k) % NUM_REQ);
      if (w_elig[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // A stalled SOP keeps its grant even if a higher-priority SOP shows up.
  assign w_holdOk = (r_state == S_IDLE) & r_hold & w_elig[r_holdIdx];

  // Grant owner: locked requester while busy, else held or fresh pick.
  always_comb begin
    w_g      = r_lockIdx;
    w_active = 1'b0;
    if (!reset_in) begin
      if (r_state == S_BUSY) begin
        w_g      = r_lockIdx;
        w_active = 1'b1;
      end else if (w_holdOk) begin
        w_g      = r_holdIdx;
        w_active = 1'b1;
      end else begin
        w_g      = w_pick;
        w_active = w_found;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    tlp_tx_arb_lane u_lane (
      .i_sel     (w_active && (w_g == idx_t'(i))),
      .i_valid   (bus.reqValid_in[i]),
      .i_sop     (bus.reqSOP_in[i]),
      .i_txReady (bus.txReady_in),
      .o_elig    (w_elig[i]),
      .o_grant   (w_grant[i]),
      .o_ready   (w_ready[i])
    );
  end

  // txValid depends only on state and requester inputs, never on txReady.
  assign w_txValid        = w_active & bus.reqValid_in[w_g];
  assign w_acc            = w_txValid & bus.txReady_in;
  assign w_rrNext         = (w_g == idx_t'(NUM_REQ - 1)) ? '0 : idx_t'(w_g + 1'b1);

  assign bus.txData_out   = bus.reqData_in[w_g];
  assign bus.txValid_out  = w_txValid;
  assign bus.txSOP_out    = w_active & bus.reqSOP_in[w_g];
  assign bus.txEOP_out    = w_active & bus.reqEOP_in[w_g];
  assign bus.reqReady_out = w_ready;
  assign bus.grant_out    = w_grant;
  assign bus.pktCount_out = r_pktCount;

  // Packet lock FSM, round-robin pointer and completed-TLP counter.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_rrPtr    <= '0;
      r_lockIdx  <= '0;
      r_holdIdx  <= '0;
      r_hold     <= 1'b0;
      r_pktCount <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hold    <= w_txValid & ~bus.txReady_in;
          r_holdIdx <= w_g;
          if (w_acc) begin
            r_rrPtr <= w_rrNext;
            if (bus.reqEOP_in[w_g]) begin
              r_pktCount <= r_pktCount + 32'd1;
            end else begin
              r_state   <= S_BUSY;
              r_lockIdx <= w_g;
            end
          end
        end
        S_BUSY: begin
          r_hold <= 1'b0;
          if (w_acc && bus.reqEOP_in[w_g]) begin
            r_state    <= S_IDLE;
            r_pktCount <= r_pktCount + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Bench for tlp_tx_arbiter (NUM_REQ=3): requester sources built from packet
// length queues, a packet-level owner/round-robin model, a per-cycle compare,
// directed scenarios with literal expectations, then a random soak.
module tb_tlp_tx_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  tlp_tx_arbiter_if #(.NUM_REQ(N)) u_bus();
  tlp_tx_arbiter #(.NUM_REQ(N)) dut (
    .pcieClk_in (clk),
    .reset_in   (rst),
    .bus        (u_bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // requester sources
  int q_len[N][$];
  int b[N];
  int seq[N];
  int bub[N];
  bit pres[N];
  int vprob = 100, rprob = 100, rstprob = 0;
  bit rst_dir = 1'b0;
  bit txr;

  // model
  int          m_owner, m_rr, m_hold;
  logic [31:0] m_cnt;
  int          e_g;
  bit          e_act, e_valid, e_sop, e_eop;

  // last sampled DUT outputs
  logic [N-1:0] s_grant, s_ready;
  logic         s_valid, s_sop, s_eop;
  logic [31:0]  s_cnt;
  logic [63:0]  s_data;

  function automatic logic [63:0] beat_data(int r);
    return {8'(r), 24'(seq[r]), 32'(b[r])};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    rst = rst_dir || (rstprob > 0 && $urandom_range(999) < rstprob);
    for (int i = 0; i < N; i++) begin
      if (!pres[i]) begin
        if (b[i] > 0 && bub[i] > 0) bub[i]--;
        else if (q_len[i].size() > 0 && $urandom_range(99) < vprob) pres[i] = 1'b1;
      end
      u_bus.reqValid_in[i] = pres[i];
      u_bus.reqSOP_in[i]   = pres[i] && b[i] == 0;
      u_bus.reqEOP_in[i]   = pres[i] && b[i] == q_len[i][0] - 1;
      u_bus.reqData_in[i]  = pres[i] ? beat_data(i) : 64'(i);
    end
    txr = $urandom_range(99) < rprob;
    u_bus.txReady_in = txr;
  endtask

  // Who owns the channel this cycle, from packet-level rules.
  task automatic model_comb();
    int c;
    e_act = 1'b0;
    e_g   = 0;
    if (!rst) begin
      if (m_owner >= 0) begin
        e_act = 1'b1; e_g = m_owner;
      end else if (m_hold >= 0 && pres[m_hold] && b[m_hold] == 0) begin
        e_act = 1'b1; e_g = m_hold;
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          c = (m_rr + k) % N;
          if (pres[c] && b[c] == 0) begin e_act = 1'b1; e_g = c; end
        end
      end
    end
    e_valid = e_act && pres[e_g];
    e_sop   = e_valid && b[e_g] == 0;
    e_eop   = e_valid && b[e_g] == q_len[e_g][0] - 1;
  endtask

  task automatic compare();
    logic [N-1:0] eg, er;
    eg = e_act ? N'(1 << e_g) : '0;
    er = (e_act && txr) ? eg : '0;
    s_grant = u_bus.grant_out;
    s_ready = u_bus.reqReady_out;
    s_valid = u_bus.txValid_out;
    s_sop   = u_bus.txSOP_out;
    s_eop   = u_bus.txEOP_out;
    s_cnt   = u_bus.pktCount_out;
    s_data  = u_bus.txData_out;
    chk("grant", 64'(s_grant), 64'(eg));
    chk("ready", 64'(s_ready), 64'(er));
    chk("txValid", 64'(s_valid), 64'(e_valid));
    chk("txSOP", 64'(s_sop), 64'(e_sop));
    chk("txEOP", 64'(s_eop), 64'(e_eop));
    chk("pktCount", 64'(s_cnt), 64'(m_cnt));
    if (e_valid) chk("txData", s_data, beat_data(e_g));
  endtask

  task automatic model_seq();
    if (rst) begin
      m_owner = -1; m_rr = 0; m_cnt = '0; m_hold = -1;
      for (int i = 0; i < N; i++) begin b[i] = 0; pres[i] = 1'b0; end
    end else begin
      if (m_owner < 0) m_hold = (e_valid && !txr) ? e_g : -1;
      if (e_valid && txr) begin
        if (m_owner < 0) m_rr = (e_g + 1) % N;
        if (e_eop) begin m_cnt = m_cnt + 32'd1; m_owner = -1; end
        else m_owner = e_g;
        b[e_g]++;
        pres[e_g] = 1'b0;
        if (b[e_g] == q_len[e_g][0]) begin
          void'(q_len[e_g].pop_front());
          b[e_g] = 0;
          seq[e_g]++;
        end
      end
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    model_comb();
    compare();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic restart();
    for (int i = 0; i < N; i++) begin
      q_len[i].delete(); bub[i] = 0; seq[i] = 0;
    end
    vprob = 100; rprob = 100; rstprob = 0;
    rst_dir = 1'b1; cycle(); cycle(); rst_dir = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  p3s, p3e, p3v;
    logic [23:0] pg8;
    logic [20:0] pg7, pr7;
    logic [6:0]  pv7;

    for (int i = 0; i < N; i++) begin b[i] = 0; pres[i] = 1'b0; seq[i] = 0; bub[i] = 0; end
    m_owner = -1; m_rr = 0; m_cnt = '0; m_hold = -1;
    u_bus.reqValid_in = '0; u_bus.reqSOP_in = '0; u_bus.reqEOP_in = '0;
    u_bus.reqData_in = '0; u_bus.txReady_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    restart();
    chk("reset pktCount", 64'(s_cnt), 64'd0);
    chk("reset grant", 64'(s_grant), 64'd0);

    // single 3-qword TLP on req0
    restart();
    q_len[0].push_back(3);
    p3s = '0; p3e = '0; p3v = '0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      p3s = {p3s[1:0], s_sop}; p3e = {p3e[1:0], s_eop}; p3v = {p3v[1:0], s_valid};
    end
    chk("3q valid pattern", 64'(p3v), 64'b111);
    chk("3q sop pattern", 64'(p3s), 64'b100);
    chk("3q eop pattern", 64'(p3e), 64'b001);
    cycle();
    chk("3q pktCount", 64'(s_cnt), 64'd1);
    chk("3q model rrPtr", 64'(m_rr), 64'd1);

    // two requesters contending with 2-qword TLPs
    restart();
    for (int k = 0; k < 4; k++) begin q_len[0].push_back(2); q_len[1].push_back(2); end
    pg8 = '0;
    for (int c = 0; c < 8; c++) begin cycle(); pg8 = {pg8[20:0], s_grant}; end
    chk("rr grant order", 64'(pg8), 64'b001_001_010_010_001_001_010_010);

    // mid-packet bubble on req1 while req0 waits with SOP
    restart();
    q_len[1].push_back(4);
    bub[1] = 2;
    cycle();
    pv7 = {6'd0, s_valid}; pg7 = {18'd0, s_grant};
    q_len[0].push_back(2);
    for (int c = 1; c < 7; c++) begin
      cycle(); pv7 = {pv7[5:0], s_valid}; pg7 = {pg7[17:0], s_grant};
    end
    chk("bubble valid pattern", 64'(pv7), 64'b1001111);
    chk("bubble grant pattern", 64'(pg7), 64'b010_010_010_010_010_010_001);

    // SOP stalled by txReady for 5 cycles, later SOP must not steal grant
    restart();
    rprob = 0;
    q_len[1].push_back(2);
    cycle();
    pg7 = {18'd0, s_grant}; pr7 = {18'd0, s_ready};
    q_len[0].push_back(2);
    for (int c = 1; c < 6; c++) begin
      if (c == 5) rprob = 100;
      cycle();
      pg7 = {pg7[17:0], s_grant}; pr7 = {pr7[17:0], s_ready};
      chk("stall data", s_data, {8'd1, 24'd0, 32'd0});
      chk("stall sop", 64'(s_sop), 64'd1);
    end
    chk("stall grant pattern", 64'(pg7[17:0]), 64'b010_010_010_010_010_010);
    chk("stall ready pattern", 64'(pr7[17:0]), 64'b000_000_000_000_000_010);

    // single-beat TLP on req2 with rrPtr at 2
    restart();
    q_len[1].push_back(1);
    cycle();
    q_len[2].push_back(1);
    q_len[0].push_back(1);
    cycle();
    chk("1beat grant", 64'(s_grant), 64'b100);
    chk("1beat sop+eop", 64'({s_sop, s_eop}), 64'b11);
    chk("1beat model rrPtr", 64'(m_rr), 64'd0);
    cycle();
    chk("1beat next grant", 64'(s_grant), 64'b001);
    chk("1beat pktCount", 64'(s_cnt), 64'd2);

    // reset in the middle of a 4-qword TLP, then restart from SOP
    restart();
    q_len[0].push_back(4);
    cycle(); cycle();
    rst_dir = 1'b1; cycle(); rst_dir = 1'b0;
    cycle();
    chk("abort pktCount", 64'(s_cnt), 64'd0);
    chk("abort restart sop", 64'({s_sop, s_eop}), 64'b10);
    cycle(); cycle(); cycle();
    chk("abort eop after restart", 64'(s_eop), 64'd1);

    // counter wrap
    force dut.r_pktCount = 32'hFFFF_FFFF;
    #1;
    release dut.r_pktCount;
    m_cnt = 32'hFFFF_FFFF;
    q_len[0].push_back(1);
    cycle();
    cycle();
    chk("wrap pktCount", 64'(s_cnt), 64'd0);

    // random soak
    restart();
    vprob = 70; rprob = 70; rstprob = 3;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q_len[i].size() < 3 && $urandom_range(3) == 0) q_len[i].push_back($urandom_range(1, 5));
        if (bub[i] == 0 && $urandom_range(15) == 0) bub[i] = $urandom_range(1, 3);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
